// File: rtl/rom_32x32.sv
// Instruction store for the small RISC-V core: 32 fixed words with a registered
// read port. The output register is cleared by reset; the table never changes.
module rom_32x32 (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  addr,
  output logic [31:0] data_out
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] rom_word;

  // Boot program; every unlisted word is a nop so no address ever reads X.
  always_comb begin
    rom_word = NOP;
    case (addr)
      5'd0:    rom_word = 32'h0010_0093;  // addi x1,x0,1
      5'd1:    rom_word = 32'h0020_0113;  // addi x2,x0,2
      5'd2:    rom_word = 32'h0020_81B3;  // add  x3,x1,x2
      5'd3:    rom_word = 32'h4011_0233;  // sub  x4,x2,x1
      5'd4:    rom_word = 32'h0020_F2B3;  // and  x5,x1,x2
      5'd5:    rom_word = 32'h0020_E333;  // or   x6,x1,x2
      5'd6:    rom_word = 32'h0020_C3B3;  // xor  x7,x1,x2
      5'd7:    rom_word = 32'h0030_2023;  // sw   x3,0(x0)
      5'd8:    rom_word = 32'h0000_2403;  // lw   x8,0(x0)
      5'd9:    rom_word = 32'h0034_0463;  // beq  x8,x3,+8
      default: rom_word = NOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) data_out <= '0;
    else     data_out <= rom_word;
  end

endmodule

// File: tb/tb_rom_32x32.sv
// Self-checking bench for rom_32x32: directed vector table, latency/stability
// sequences and randomized access against a program-list reference model.
module tb_rom_32x32;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  addr;
  logic [31:0] data_out;

  int n_checks = 0;
  int n_fail   = 0;

  rom_32x32 dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  // Reference: the program as listed, everything past its end reads as nop.
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [31:0] prog [10] = '{
    32'h00100093, 32'h00200113, 32'h002081B3, 32'h40110233, 32'h0020F2B3,
    32'h0020E333, 32'h0020C3B3, 32'h00302023, 32'h00002403, 32'h00340463
  };

  function automatic logic [31:0] ref_word(input int a);
    return (a < 10) ? prog[a] : NOP;
  endfunction

  typedef struct {
    bit          rst;
    logic [4:0]  addr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: data_out=%h expected=%h", nm, act, exp);
    end
  endtask

  // Drive inputs just after an edge, then compare just after the next edge.
  task automatic apply(input bit r, input logic [4:0] a, input logic [31:0] e, input string nm);
    rst  = r;
    addr = a;
    @(posedge clk);
    #1;
    check(nm, data_out, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    addr = 5'd5;

    // Reset hold, release, wrap, mid-sweep reset; expected values are literals.
    vecs.push_back('{1'b1, 5'd5,  32'h00000000});
    vecs.push_back('{1'b1, 5'd5,  32'h00000000});
    vecs.push_back('{1'b0, 5'd5,  32'h0020E333});
    vecs.push_back('{1'b0, 5'd31, 32'h00000013});
    vecs.push_back('{1'b0, 5'd0,  32'h00100093});
    vecs.push_back('{1'b0, 5'd7,  32'h00302023});
    vecs.push_back('{1'b0, 5'd8,  32'h00002403});
    vecs.push_back('{1'b0, 5'd31, 32'h00000013});
    vecs.push_back('{1'b0, 5'd5,  32'h0020E333});
    vecs.push_back('{1'b1, 5'd6,  32'h00000000});
    vecs.push_back('{1'b0, 5'd6,  32'h0020C3B3});
    // Full sweep 0..31 then wrap to 0.
    for (int a = 0; a < 32; a++) vecs.push_back('{1'b0, 5'(a), ref_word(a)});
    vecs.push_back('{1'b0, 5'd0, 32'h00100093});

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i].rst, vecs[i].addr, vecs[i].exp, $sformatf("vec[%0d] addr=%0d rst=%0d", i, vecs[i].addr, vecs[i].rst));

    // Latency: addr changes right after the edge; output must not follow it.
    apply(1'b0, 5'd3, 32'h40110233, "lat_load3");
    addr = 5'd4;
    #1 check("lat_hold_early", data_out, 32'h40110233);
    @(negedge clk);
    check("lat_hold_mid", data_out, 32'h40110233);
    @(posedge clk);
    #1 check("lat_next4", data_out, 32'h0020F2B3);

    // Stability: addr=1 for 10 edges, also sampled between edges.
    for (int k = 0; k < 10; k++) begin
      apply(1'b0, 5'd1, 32'h00200113, $sformatf("stable_edge%0d", k));
      @(negedge clk);
      check($sformatf("stable_mid%0d", k), data_out, 32'h00200113);
    end

    // Randomized access with occasional reset pulses.
    for (int k = 0; k < 300; k++) begin
      bit   r;
      int   a;
      r = ($urandom_range(0, 7) == 0);
      a = $urandom_range(0, 31);
      apply(r, 5'(a), r ? 32'h0 : ref_word(a), $sformatf("rand%0d addr=%0d rst=%0d", k, a, r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
